// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED controller input block.
package led_ctrl_pkg;
  localparam int DB_LEN_DEF    = 16;
  localparam int FAST_LOG2_DEF = 24;
  localparam int SLOW_LOG2_DEF = 27;

  localparam logic SPEED_FAST = 1'b0;
  localparam logic SPEED_SLOW = 1'b1;

  localparam int NUM_BTN   = 2;
  localparam int BTN_EN    = 0;
  localparam int BTN_SPEED = 1;
endpackage

// File: rtl/led_ctrl_input_btn_conditioner.sv
// Push-button conditioner: 2-flop sync, optional debounce, rising-edge pulse.
// Debounce window is compiled in only when LED_CTRL_DEBOUNCE_EN is defined.
module btn_conditioner
  import led_ctrl_pkg::*;
#(
  parameter int DB_LEN = DB_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  if (DB_LEN < 2 || DB_LEN > 64) begin : g_bad_db_len
    $error("btn_conditioner: DB_LEN must be within 2..64");
  end

  logic [1:0] sync;
  logic       db;
  logic       db_nxt;

`ifdef LED_CTRL_DEBOUNCE_EN
  logic [DB_LEN-1:0] sr;

  // Level only moves on a unanimous window; mixed samples hold it.
  always_comb begin
    db_nxt = db;
    if (&sr)       db_nxt = 1'b1;
    else if (~|sr) db_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[DB_LEN-2:0], sync[1]};
  end
`else
  assign db_nxt = sync[1];
`endif

  // db holds the previous level, so the pulse marks the cycle the level rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      db    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      db    <= db_nxt;
      pulse <= db_nxt & ~db;
    end
  end

endmodule

// File: rtl/led_ctrl_input.sv
// LED controller input: button toggles for en/speed plus a rate-selected tick.
// Build option LED_CTRL_DEBOUNCE_EN enables the debounce window in each button path.
module led_ctrl_input
  import led_ctrl_pkg::*;
#(
  parameter int DB_LEN    = DB_LEN_DEF,
  parameter int FAST_LOG2 = FAST_LOG2_DEF,
  parameter int SLOW_LOG2 = SLOW_LOG2_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_en,
  input  logic btn_speed,
  output logic en,
  output logic speed,
  output logic tick
);

  if (SLOW_LOG2 <= FAST_LOG2 || FAST_LOG2 < 1) begin : g_bad_log2
    $error("led_ctrl_input: need 1 <= FAST_LOG2 < SLOW_LOG2");
  end

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] pulse;

  assign raw[BTN_EN]    = btn_en;
  assign raw[BTN_SPEED] = btn_speed;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_conditioner #(.DB_LEN(DB_LEN)) u_cond (
      .clk  (clk),
      .rst  (rst),
      .btn  (raw[b]),
      .pulse(pulse[b])
    );
  end

  logic [SLOW_LOG2-1:0] cnt;
  logic                 fast_hit;
  logic                 slow_hit;

  assign fast_hit = &cnt[FAST_LOG2-1:0];
  assign slow_hit = &cnt;

  // cnt free-runs through speed changes so a rate switch never restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      en    <= 1'b0;
      speed <= SPEED_FAST;
      tick  <= 1'b0;
    end else begin
      cnt   <= cnt + 1'b1;
      en    <= en ^ pulse[BTN_EN];
      speed <= speed ^ pulse[BTN_SPEED];
      tick  <= en & ((speed == SPEED_SLOW) ? slow_hit : fast_hit);
    end
  end

endmodule

// File: tb/tb_led_ctrl_input.sv
// Scoreboard bench for led_ctrl_input (DB_LEN=4, FAST_LOG2=3, SLOW_LOG2=5).
// Expected toggle latency follows LED_CTRL_DEBOUNCE_EN.
module tb_led_ctrl_input;
  localparam int DB_LEN    = 4;
  localparam int FAST_LOG2 = 3;
  localparam int SLOW_LOG2 = 5;
`ifdef LED_CTRL_DEBOUNCE_EN
  localparam int LAT  = DB_LEN + 4;
  localparam bit NODB = 1'b0;
`else
  localparam int LAT  = 4;
  localparam bit NODB = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst, btn_en, btn_speed;
  logic en, speed, tick;

  led_ctrl_input #(.DB_LEN(DB_LEN), .FAST_LOG2(FAST_LOG2), .SLOW_LOG2(SLOW_LOG2)) dut (
    .clk(clk), .rst(rst), .btn_en(btn_en), .btn_speed(btn_speed),
    .en(en), .speed(speed), .tick(tick)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  logic [2:0] exp_q[$];

  logic [SLOW_LOG2-1:0] m_cnt;
  logic m_en, m_sp, m_tick;

  // One clock edge: advance the reference model and queue its {en,speed,tick}.
  task automatic cyc(input logic t_en, input logic t_sp);
    @(posedge clk);
    if (rst) begin
      m_cnt = '0; m_en = 1'b0; m_sp = 1'b0; m_tick = 1'b0;
    end else begin
      m_tick = m_en & (m_sp ? (&m_cnt) : (&m_cnt[FAST_LOG2-1:0]));
      m_cnt  = m_cnt + 1'b1;
      m_en   = m_en ^ t_en;
      m_sp   = m_sp ^ t_sp;
    end
    exp_q.push_back({m_en, m_sp, m_tick});
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; btn_en = 1'b0; btn_speed = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [2:0] exp;
    rst = 1'b1; btn_en = 1'b1; btn_speed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL reset cyc %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
    btn_en = 1'b0; btn_speed = 1'b0;
    cyc(1'b0, 1'b0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_en_press;
    logic [2:0] exp;
    apply_reset();
    for (int i = 1; i <= 48; i++) begin
      btn_en = (i <= 12);
      cyc(i == LAT, 1'b0);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL en_press edge %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
  endtask

  task automatic test_glitch;
    logic [2:0] exp;
    apply_reset();
    for (int i = 1; i <= 24; i++) begin
      btn_en = (i <= 3);
      cyc(NODB && (i == 4), 1'b0);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL glitch edge %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
  endtask

  task automatic test_one_pulse;
    logic [2:0] exp;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      btn_en = (i == 1);
      cyc(NODB && (i == 4), 1'b0);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL one_pulse edge %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
  endtask

  // en on, switch to slow mid-period, then en off again.
  task automatic test_speed;
    logic [2:0] exp;
    apply_reset();
    for (int i = 1; i <= 140; i++) begin
      btn_en    = (i <= 12) || (i >= 110 && i <= 120);
      btn_speed = (i >= 20 && i <= 30);
      cyc((i == LAT) || (i == 109 + LAT), i == 19 + LAT);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL speed edge %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
  endtask

  task automatic test_both;
    logic [2:0] exp;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      btn_en    = (i <= 12);
      btn_speed = (i <= 12);
      cyc(i == LAT, i == LAT);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL both edge %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
  endtask

  task automatic test_rst_mid;
    logic [2:0] exp;
    apply_reset();
    btn_en = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      rst = (i == 5 || i == 6);
      // edges after the reset are renumbered from 1 for the toggle
      cyc((i <= 4) ? (i == LAT) : (i - 6 == LAT), 1'b0);
      exp = exp_q.pop_front();
      nchk++;
      if ({en, speed, tick} !== exp) begin
        nfail++;
        $display("FAIL rst_mid edge %0d: got %b want %b", i, {en, speed, tick}, exp);
      end
    end
    btn_en = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_en = 1'b0; btn_speed = 1'b0;
    m_cnt = '0; m_en = 1'b0; m_sp = 1'b0; m_tick = 1'b0;
    test_reset();
    test_en_press();
    test_glitch();
    test_one_pulse();
    test_speed();
    test_both();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/led_ctrl_input.md
LED_CTRL_INPUT -- requirements
Module: led_ctrl_input

Interface
REQ-001 Parameter DB_LEN, default 16: debounce window in clk cycles, legal range 2..64.
REQ-002 Parameter FAST_LOG2, default 24: log2 of the tick period when speed=0.
REQ-003 Parameter SLOW_LOG2, default 27: log2 of the tick period when speed=1; SHALL be greater than FAST_LOG2.
REQ-004 clk  input  1  single system clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_en  input  1  raw asynchronous push-button; each press toggles en.
REQ-007 btn_speed  input  1  raw asynchronous push-button; each press toggles speed.
REQ-008 en  output  1  registered run-enable level.
REQ-009 speed  output  1  registered rate select: 0 = fast, 1 = slow.
REQ-010 tick  output  1  registered single-cycle step strobe for the LED shifter.

Function
REQ-011 Each button path SHALL pass through a 2-flop synchronizer, then a debounce stage, then a rising-edge one-pulse stage.
REQ-012 Debounce stage: shift register of the last DB_LEN synchronized samples.
  - Debounced level goes to 1 when all samples are 1.
  - Debounced level goes to 0 when all samples are 0.
  - Otherwise the debounced level holds.
REQ-013 Pulse stage SHALL be registered: pulse = debounced level & ~previous debounced level.
REQ-014 If raw input is first sampled high at edge 1 and stays high, en/speed SHALL toggle at edge DB_LEN+4, exactly once.
REQ-015 Raw high glitches shorter than DB_LEN cycles SHALL cause no toggle.
REQ-016 Holding a button SHALL produce no further toggles; a new toggle requires a debounced release followed by a new press.
REQ-017 Simultaneous presses of both buttons SHALL toggle en and speed independently in the same cycle.
REQ-018 Free-running counter cnt, SLOW_LOG2 bits wide: increments every cycle regardless of en, wraps modulo 2^SLOW_LOG2.
REQ-019 tick SHALL be registered as: en & (speed ? cnt[SLOW_LOG2-1:0] all ones : cnt[FAST_LOG2-1:0] all ones).
  - tick period is 2^FAST_LOG2 cycles when speed=0.
  - tick period is 2^SLOW_LOG2 cycles when speed=1.
REQ-020 A speed change SHALL NOT reset cnt; the next tick uses the new select at the next all-ones match.
REQ-021 When en goes to 0, tick SHALL be 0 from the following edge onward; no tick is owed when en is re-enabled.

Reset
REQ-022 While rst=1 at a posedge, the following SHALL clear to 0: synchronizers, shift registers, debounced levels, previous levels, pulses, cnt, en, speed and tick.
REQ-023 A button held through rst deassertion SHALL produce exactly one toggle after the REQ-014 latency, counted from the first post-reset edge.
REQ-024 Assertion of rst mid-debounce or mid-period SHALL discard all partial state, with no residual pulse.

Configuration
REQ-025 Macro LED_CTRL_DEBOUNCE_EN, when defined, compiles the DB_LEN debounce stage in.
REQ-026 When LED_CTRL_DEBOUNCE_EN is undefined:
  - the debounced level SHALL be the synchronizer output registered once;
  - toggle latency SHALL be 4 edges;
  - every synchronized rising edge toggles, bounce included.

Structure
REQ-027 Shared package led_ctrl_pkg SHALL hold:
  - default constants DB_LEN_DEF=16, FAST_LOG2_DEF=24, SLOW_LOG2_DEF=27;
  - the speed encoding constants SPEED_FAST=0 and SPEED_SLOW=1.
REQ-028 Sub-module btn_conditioner (synchronizer + debounce + one-pulse, parameter DB_LEN) SHALL be instantiated once per button.

Verification (bench uses DB_LEN=4, FAST_LOG2=3, SLOW_LOG2=5)
REQ-029 rst high 2 cycles, then btn_en held high from edge 1 -> en=1 at edge 8, tick every 8 cycles, speed=0.
REQ-030 btn_en high for 3 cycles then low -> en remains 0, no tick.
REQ-031 en=1, press btn_speed -> after toggle, tick spacing 32 cycles; cnt not disturbed, so the first slow tick lands at the next cnt=31.
REQ-032 Both buttons pressed in the same cycle from reset -> en=1 and speed=1 at the same edge 8.
REQ-033 rst asserted at edge 5 of a press, button held -> en=0 during rst, then en=1 exactly 8 edges after rst deasserts.
REQ-034 Without LED_CTRL_DEBOUNCE_EN, a 1-cycle-wide pulse on btn_en -> en=1 at edge 4.
